// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with optional
// write forwarding, one synchronous write port, a debug read port and a write counter.
module reg_file #(
  parameter int WIDTH    = 10,
  parameter int NREG     = 4,
  parameter int AW       = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [7:0]       wr_count_q;
  logic [7:0]       wr_count_d;
  logic             wr_acc;
  logic             wr_fwd;
  logic             zero_rs;
  logic             zero_rt;
  logic             zero_dbg;

  assign wr_acc = we && !((ZERO_REG != 0) && (waddr == '0));
  // Forwarding is gated by rst_n so reads stay 0 throughout reset.
  assign wr_fwd = rst_n && wr_acc && (BYPASS != 0);

  assign zero_rs  = (ZERO_REG != 0) && (rs_addr == '0);
  assign zero_rt  = (ZERO_REG != 0) && (rt_addr == '0);
  assign zero_dbg = (ZERO_REG != 0) && (dbg_addr == '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_acc) begin
      regs_d[waddr] = wdata;
      if (wr_count_q != '1) begin
        wr_count_d = wr_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rs_data  = regs_q[rs_addr];
    rt_data  = regs_q[rt_addr];
    dbg_data = regs_q[dbg_addr];
    if (wr_fwd && (rs_addr == waddr)) begin
      rs_data = wdata;
    end
    if (wr_fwd && (rt_addr == waddr)) begin
      rt_data = wdata;
    end
    if (!rst_n || zero_rs) begin
      rs_data = '0;
    end
    if (!rst_n || zero_rt) begin
      rt_data = '0;
    end
    if (!rst_n || zero_dbg) begin
      dbg_data = '0;
    end
  end

  assign wr_count = rst_n ? wr_count_q : 8'd0;

endmodule
